// File: rtl/stats_regfile_avlstrm_pkg.sv
// Shared stats channel definitions: record layout, register addresses and host read map.
package stats_regfile_avlstrm_pkg;

  localparam int STATS_VAL_W  = 32;
  localparam int STATS_ADDR_W = 8;

  typedef struct packed {
    logic [STATS_ADDR_W-1:0] addr;
    logic [STATS_VAL_W-1:0]  val;
  } stats_t;

  localparam logic [STATS_ADDR_W-1:0] REG_RX_PKTS  = 8'd0;
  localparam logic [STATS_ADDR_W-1:0] REG_TX_PKTS  = 8'd1;
  localparam logic [STATS_ADDR_W-1:0] REG_RX_BYTES = 8'd2;
  localparam logic [STATS_ADDR_W-1:0] REG_TX_BYTES = 8'd3;
  localparam logic [STATS_ADDR_W-1:0] REG_RX_DROPS = 8'd4;

  // Offsets above NUM_REGS where the receiver exposes its own counters.
  localparam int STATS_RD_SNAP_CNT  = 0;
  localparam int STATS_RD_DROP      = 1;
  localparam int STATS_RD_MALFORMED = 2;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } rx_state_t;

  function automatic logic [STATS_VAL_W-1:0] sat_inc(input logic [STATS_VAL_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stats_shadow_bank.sv
// Shadow array plus presence mask; on commit emits live-bank write enables for every staged entry.
module stats_shadow_bank
  import stats_regfile_avlstrm_pkg::*;
#(
  parameter int NUM_REGS = 64,
  parameter int AW       = 6
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_wr,
  input  logic [AW-1:0]                         i_wr_addr,
  input  logic [STATS_VAL_W-1:0]                i_wr_val,
  input  logic                                  i_clear,
  input  logic                                  i_commit,
  output logic [NUM_REGS-1:0]                   o_live_we,
  output logic [NUM_REGS-1:0][STATS_VAL_W-1:0]  o_live_wd
);

  logic [NUM_REGS-1:0][STATS_VAL_W-1:0] r_shadow;
  logic [NUM_REGS-1:0]                  r_mask;
  logic [NUM_REGS-1:0][STATS_VAL_W-1:0] w_shadow_eff;
  logic [NUM_REGS-1:0]                  w_mask_eff;

  // The beat accepted this cycle is folded in so an eop beat commits its own record.
  always_comb begin
    w_mask_eff   = i_clear ? '0 : r_mask;
    w_shadow_eff = r_shadow;
    if (i_wr) begin
      w_mask_eff[i_wr_addr]   = 1'b1;
      w_shadow_eff[i_wr_addr] = i_wr_val;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_mask   <= '0;
    end else begin
      r_shadow <= w_shadow_eff;
      r_mask   <= i_commit ? '0 : w_mask_eff;
    end
  end

  assign o_live_we = i_commit ? w_mask_eff : '0;
  assign o_live_wd = w_shadow_eff;

endmodule

// File: rtl/stats_regfile_avlstrm.sv
// Avalon-ST stats sink feeding a host-readable register file; never backpressures, reads return next cycle.
// STATS_SHADOW_EN: defined = atomic snapshot commit on eop via stats_shadow_bank; undefined = direct live writes.
module stats_regfile_avlstrm
  import stats_regfile_avlstrm_pkg::*;
#(
  parameter int NUM_REGS = 64,
  parameter int DATA_W   = 512,
  parameter int EMPTY_W  = $clog2(DATA_W/8)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_stats_in_valid,
  output logic                   o_stats_in_ready,
  input  logic [DATA_W-1:0]      i_stats_in_data,
  input  logic                   i_stats_in_sop,
  input  logic                   i_stats_in_eop,
  input  logic [EMPTY_W-1:0]     i_stats_in_empty,
  input  logic                   i_rd_en,
  input  logic [7:0]             i_rd_addr,
  output logic [STATS_VAL_W-1:0] o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_snap_done
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  rx_state_t r_state, w_state_nxt;
  logic      r_ready;
  logic [STATS_VAL_W-1:0] r_snap_cnt, r_drop_cnt, r_malformed_cnt;
  logic [NUM_REGS-1:0][STATS_VAL_W-1:0] r_live;
  logic [STATS_VAL_W-1:0] r_rd_data;
  logic      r_rd_valid;
  logic      r_snap_done;

  stats_t    w_rec;
  logic      w_acc, w_in_range, w_stage, w_clear, w_commit, w_malformed, w_wr, w_drop;
  logic [AW-1:0] w_wr_addr;
  logic [NUM_REGS-1:0]                  w_live_we;
  logic [NUM_REGS-1:0][STATS_VAL_W-1:0] w_live_wd;
  logic [STATS_VAL_W-1:0] w_rd_mux;
  logic      w_unused_bits;

  assign w_rec         = i_stats_in_data[$bits(stats_t)-1:0];
  assign w_acc         = i_stats_in_valid & r_ready;
  assign w_in_range    = int'(w_rec.addr) < NUM_REGS;
  assign w_wr_addr     = w_rec.addr[AW-1:0];
  assign w_wr          = w_stage & w_in_range;
  assign w_drop        = w_stage & ~w_in_range;
  assign w_unused_bits = ^{i_stats_in_empty, i_stats_in_data[DATA_W-1:$bits(stats_t)], w_clear};

  always_comb begin
    w_state_nxt = r_state;
    w_stage     = 1'b0;
    w_clear     = 1'b0;
    w_commit    = 1'b0;
    w_malformed = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (i_stats_in_sop) begin
            w_stage = 1'b1;
            if (i_stats_in_eop) w_commit = 1'b1;
            else                w_state_nxt = ST_COLLECT;
          end else begin
            w_malformed = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        if (w_acc) begin
          w_stage = 1'b1;
          // A fresh sop abandons the partial snapshot and restarts with this record.
          if (i_stats_in_sop) begin
            w_clear     = 1'b1;
            w_malformed = 1'b1;
          end
          if (i_stats_in_eop) begin
            w_commit    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef STATS_SHADOW_EN
  stats_shadow_bank #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_shadow (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr      (w_wr),
    .i_wr_addr (w_wr_addr),
    .i_wr_val  (w_rec.val),
    .i_clear   (w_clear),
    .i_commit  (w_commit),
    .o_live_we (w_live_we),
    .o_live_wd (w_live_wd)
  );
`else
  always_comb begin
    w_live_we = '0;
    if (w_wr) w_live_we[w_wr_addr] = 1'b1;
  end
  assign w_live_wd = {NUM_REGS{w_rec.val}};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_live <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_live_we[i]) r_live[i] <= w_live_wd[i];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_ready         <= 1'b0;
      r_snap_cnt      <= '0;
      r_drop_cnt      <= '0;
      r_malformed_cnt <= '0;
      r_snap_done     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= 1'b1;
      r_snap_done <= w_commit;
      if (w_commit)    r_snap_cnt      <= sat_inc(r_snap_cnt);
      if (w_drop)      r_drop_cnt      <= sat_inc(r_drop_cnt);
      if (w_malformed) r_malformed_cnt <= sat_inc(r_malformed_cnt);
    end
  end

  // Sampled from registered state, so a read coinciding with a commit sees the old value.
  always_comb begin
    w_rd_mux = '0;
    if (int'(i_rd_addr) < NUM_REGS)
      w_rd_mux = r_live[i_rd_addr[AW-1:0]];
    else if (int'(i_rd_addr) == NUM_REGS + STATS_RD_SNAP_CNT)
      w_rd_mux = r_snap_cnt;
    else if (int'(i_rd_addr) == NUM_REGS + STATS_RD_DROP)
      w_rd_mux = r_drop_cnt;
    else if (int'(i_rd_addr) == NUM_REGS + STATS_RD_MALFORMED)
      w_rd_mux = r_malformed_cnt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign o_stats_in_ready = r_ready;
  assign o_rd_data        = r_rd_data;
  assign o_rd_valid       = r_rd_valid;
  assign o_snap_done      = r_snap_done;

endmodule
